// File: rtl/micro_sequencer_if.sv
// Sequencing bus between the microinstruction/encoder side and micro_sequencer.
interface micro_sequencer_if #(
    parameter int unsigned STATE_W = 8
);
    logic [STATE_W-1:0] enc_state;
    logic [3:0]         ir_cond;
    logic [3:0]         flags;
    logic               moc;
    logic [2:0]         ns_sel;
    logic [1:0]         cond_sel;
    logic               inv;
    logic [STATE_W-1:0] cr_addr;
    logic [STATE_W-1:0] state;
    logic               cond_pass;
    logic               stall;
    logic               mem_abort;

    modport master (
        output enc_state, ir_cond, flags, moc, ns_sel, cond_sel, inv, cr_addr,
        input  state, cond_pass, stall, mem_abort
    );

    modport slave (
        input  enc_state, ir_cond, flags, moc, ns_sel, cond_sel, inv, cr_addr,
        output state, cond_pass, stall, mem_abort
    );
endinterface

// File: rtl/micro_sequencer.sv
// Next-state address unit of the microprogrammed control unit.
// Optional MOC watchdog: define MICRO_SEQ_MOC_TIMEOUT_EN.
module micro_sequencer #(
    parameter int unsigned        STATE_W     = 8,
    parameter logic [STATE_W-1:0] RESET_STATE = '0,
    parameter logic [STATE_W-1:0] FETCH_STATE = STATE_W'(1),
    parameter logic [STATE_W-1:0] UNDEF_STATE = '1
`ifdef MICRO_SEQ_MOC_TIMEOUT_EN
    ,
    parameter int unsigned        TIMEOUT     = 16,
    parameter logic [STATE_W-1:0] ABORT_STATE = STATE_W'(254)
`endif
) (
    input  logic                clk,
    input  logic                reset,
    micro_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        NS_INC       = 3'b000,
        NS_JUMP      = 3'b001,
        NS_DISPATCH  = 3'b010,
        NS_CJUMP     = 3'b011,
        NS_WAIT_MOC  = 3'b100,
        NS_CDISPATCH = 3'b101,
        NS_CALL      = 3'b110,
        NS_RETURN    = 3'b111
    } ns_op_e;

    ns_op_e             op;
    logic [STATE_W-1:0] state_q, state_nxt;
    logic [STATE_W-1:0] ret_q, ret_nxt;
    logic [STATE_W-1:0] state_inc;
    logic [STATE_W-1:0] dispatch_tgt;
    logic               cond_pass;
    logic               test_bit;
    logic               waiting;
    logic               n_f, z_f, c_f, v_f;

    assign op           = ns_op_e'(bus.ns_sel);
    assign {n_f, z_f, c_f, v_f} = bus.flags;
    assign state_inc    = state_q + STATE_W'(1);
    assign dispatch_tgt = (bus.enc_state == '0) ? UNDEF_STATE : bus.enc_state;
    assign waiting      = (op == NS_WAIT_MOC) && !bus.moc;

    // ARM condition-code evaluation against NZCV.
    always_comb begin
        cond_pass = 1'b0;
        case (bus.ir_cond)
            4'h0: cond_pass = z_f;
            4'h1: cond_pass = !z_f;
            4'h2: cond_pass = c_f;
            4'h3: cond_pass = !c_f;
            4'h4: cond_pass = n_f;
            4'h5: cond_pass = !n_f;
            4'h6: cond_pass = v_f;
            4'h7: cond_pass = !v_f;
            4'h8: cond_pass = c_f && !z_f;
            4'h9: cond_pass = !c_f || z_f;
            4'hA: cond_pass = (n_f == v_f);
            4'hB: cond_pass = (n_f != v_f);
            4'hC: cond_pass = !z_f && (n_f == v_f);
            4'hD: cond_pass = z_f || (n_f != v_f);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Branch test mux for CJUMP.
    always_comb begin
        test_bit = 1'b0;
        case (bus.cond_sel)
            2'd0:    test_bit = bus.moc;
            2'd1:    test_bit = cond_pass;
            2'd2:    test_bit = z_f;
            default: test_bit = n_f;
        endcase
    end

`ifdef MICRO_SEQ_MOC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_nxt;
    logic             abort_nxt;
    logic             wd_expired;

    assign wd_expired = waiting && (wd_cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    // Next-state and return-register selection.
    always_comb begin
        state_nxt = state_q;
        ret_nxt   = ret_q;
        case (op)
            NS_INC:       state_nxt = state_inc;
            NS_JUMP:      state_nxt = bus.cr_addr;
            NS_DISPATCH:  state_nxt = dispatch_tgt;
            NS_CJUMP:     state_nxt = (test_bit ^ bus.inv) ? bus.cr_addr : state_inc;
            NS_WAIT_MOC:  state_nxt = bus.moc ? state_inc : state_q;
            NS_CDISPATCH: state_nxt = cond_pass ? dispatch_tgt : FETCH_STATE;
            NS_CALL: begin
                state_nxt = bus.cr_addr;
                ret_nxt   = state_inc;
            end
            default:      state_nxt = ret_q;
        endcase
`ifdef MICRO_SEQ_MOC_TIMEOUT_EN
        abort_nxt  = 1'b0;
        wd_cnt_nxt = waiting ? wd_cnt_q + CNT_W'(1) : '0;
        if (wd_expired) begin
            state_nxt  = ABORT_STATE;
            abort_nxt  = 1'b1;
            wd_cnt_nxt = '0;
        end
`endif
    end

    // Control-store address and return register; reset overrides every ns_sel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            ret_q   <= '0;
        end else begin
            state_q <= state_nxt;
            ret_q   <= ret_nxt;
        end
    end

`ifdef MICRO_SEQ_MOC_TIMEOUT_EN
    logic mem_abort_q;

    // MOC watchdog counter and abort pulse, aligned with entry to ABORT_STATE.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q    <= '0;
            mem_abort_q <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_nxt;
            mem_abort_q <= abort_nxt;
        end
    end

    assign bus.mem_abort = mem_abort_q;
`else
    assign bus.mem_abort = 1'b0;
`endif

    assign bus.state     = state_q;
    assign bus.cond_pass = cond_pass;
    assign bus.stall     = waiting && !reset;

endmodule
